// File: rtl/lab2_circuitb_serial_decoder.sv
// Excess-OFFSET decoder: restores an encoded word as (in_data + OFFSET) mod 2^WIDTH
// using a bit-serial adder that runs LSB-first, one bit per clock, with valid/ready handshakes.
module lab2_circuitb_serial_decoder #(
    parameter int               WIDTH  = 3,
    parameter logic [WIDTH-1:0] OFFSET = 3'b010
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opnd_q, opnd_d;
    logic [WIDTH-1:0] cnst_q, cnst_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             out_carry_q, out_carry_d;

    logic sum_bit;
    logic carry_nxt;

    assign sum_bit   = opnd_q[0] ^ cnst_q[0] ^ carry_q;
    assign carry_nxt = (opnd_q[0] & cnst_q[0]) | (opnd_q[0] & carry_q) | (cnst_q[0] & carry_q);

    always_comb begin
        state_d     = state_q;
        opnd_d      = opnd_q;
        cnst_d      = cnst_q;
        result_d    = result_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        out_data_d  = out_data_q;
        out_carry_d = out_carry_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    opnd_d  = in_data;
                    cnst_d  = OFFSET;
                    carry_d = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                carry_d  = carry_nxt;
                result_d = {sum_bit, result_q[WIDTH-1:1]};
                opnd_d   = opnd_q >> 1;
                cnst_d   = cnst_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                // Output copy is taken only on the last bit, so a partial sum is never visible.
                if (cnt_q == CW'(WIDTH - 1)) begin
                    cnt_d       = '0;
                    out_data_d  = {sum_bit, result_q[WIDTH-1:1]};
                    out_carry_d = carry_nxt;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opnd_q      <= '0;
            cnst_q      <= '0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            out_data_q  <= '0;
            out_carry_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            opnd_q      <= opnd_d;
            cnst_q      <= cnst_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            out_data_q  <= out_data_d;
            out_carry_q <= out_carry_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;
    assign out_carry = out_carry_q;

endmodule

// File: tb/tb_lab2_circuitb_serial_decoder.sv
// Scoreboard bench for the serial excess-2 decoder: expected words are queued at accept
// and compared when out_valid appears.
module tb_lab2_circuitb_serial_decoder;
    localparam int WIDTH = 3;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_carry;
    logic             busy;

    int errors = 0;
    int checks = 0;
    logic [WIDTH:0] sb_q[$];

    lab2_circuitb_serial_decoder #(.WIDTH(WIDTH), .OFFSET(3'b010)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_carry(out_carry),
        .busy     (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic pop_and_check(input string tag);
        logic [WIDTH:0] e;
        if (sb_q.size() == 0) begin
            check_eq({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check_eq({tag, "_data"}, 32'(out_data), 32'(e[WIDTH-1:0]));
            check_eq({tag, "_carry"}, 32'(out_carry), 32'(e[WIDTH]));
        end
    endtask

    task automatic do_word(input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] ed,
                           input logic ec, input string tag);
        int n;
        in_data   = d;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        check_eq({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        sb_q.push_back({ec, ed});
        tick();
        in_valid = 1'b0;
        wait_valid(n);
        check_eq({tag, "_latency"}, 32'(n), 32'(WIDTH));
        pop_and_check(tag);
        tick();
        check_eq({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        int n;
        int seen;
        logic [WIDTH-1:0] enc;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 3'b101;
        out_ready = 1'b0;

        // T1: reset with in_valid asserted
        tick();
        tick();
        check_eq("rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_data", 32'(out_data), 32'd0);
        check_eq("rst_out_carry", 32'(out_carry), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        tick();
        check_eq("rst_no_capture", 32'(busy), 32'd0);

        // T2 / T3
        do_word(3'b011, 3'b101, 1'b0, "basic_3");
        do_word(3'b110, 3'b000, 1'b1, "wrap_6");
        do_word(3'b111, 3'b001, 1'b1, "wrap_7");

        // T4: encoder (x-2 mod 8) then decoder must give x back
        for (int x = 0; x < 8; x++) begin
            enc = 3'(x - 2);
            do_word(enc, 3'(x), (enc >= 3'd6), $sformatf("trip_%0d", x));
        end

        // T5: backpressure in DONE with a second word waiting
        out_ready = 1'b0;
        in_data   = 3'b100;
        in_valid  = 1'b1;
        sb_q.push_back({1'b0, 3'b110});
        tick();
        in_data = 3'b001;
        wait_valid(n);
        check_eq("bp_latency", 32'(n), 32'(WIDTH));
        for (int i = 0; i < 5; i++) begin
            check_eq($sformatf("bp_hold_valid_%0d", i), 32'(out_valid), 32'd1);
            check_eq($sformatf("bp_hold_data_%0d", i), 32'(out_data), 32'b110);
            check_eq($sformatf("bp_in_ready_%0d", i), 32'(in_ready), 32'd0);
            tick();
        end
        pop_and_check("bp_first");
        out_ready = 1'b1;
        tick();
        check_eq("bp_idle_valid", 32'(out_valid), 32'd0);
        check_eq("bp_idle_ready", 32'(in_ready), 32'd1);
        check_eq("bp_idle_busy", 32'(busy), 32'd0);
        sb_q.push_back({1'b0, 3'b011});
        tick();
        in_valid = 1'b0;
        check_eq("bp_second_taken", 32'(busy), 32'd1);
        wait_valid(n);
        check_eq("bp_second_latency", 32'(n), 32'(WIDTH));
        pop_and_check("bp_second");
        tick();

        // T6: reset on the second SHIFT edge discards the word
        out_ready = 1'b1;
        in_data   = 3'b101;
        in_valid  = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_rst_busy", 32'(busy), 32'd0);
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check_eq("mid_rst_out_data", 32'(out_data), 32'd0);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid) seen++;
            tick();
        end
        check_eq("mid_rst_no_valid", 32'(seen), 32'd0);
        do_word(3'b001, 3'b011, 1'b0, "post_rst");

        check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
